// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and state encoding for the uart frame parser
package uart_frame_pkg;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  localparam logic [1:0] ERR_OVR = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload buffer: simple dual-port RAM, sync write, registered read
module uart_frame_buf #(
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a same-cycle write is seen on the following read only.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - detects 55 AA CMD LEN payload CHK frames from the uart_rx byte stream
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF,
  localparam int        ADDR_W      = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_din,
  input  logic              rx_vld,
  output logic              frm_vld,
  output logic [7:0]        frm_cmd,
  output logic [ADDR_W:0]   frm_len,
  input  logic              frm_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              vld_d, err_d;
  logic [7:0]        fcmd_d;
  logic [ADDR_W:0]   flen_d;
  logic [1:0]        code_d;
  logic              wr_en;

  assign wr_en = (state_q == ST_DATA) && rx_vld;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    vld_d   = frm_vld;
    fcmd_d  = frm_cmd;
    flen_d  = frm_len;
    err_d   = 1'b0;
    code_d  = err_code;
    case (state_q)
      ST_HDR0: begin
        cnt_d = '0;
        if (rx_vld && rx_din == HDR0) state_d = ST_HDR1;
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (rx_vld) begin
          err_d  = 1'b1;
          code_d = ERR_OVR;
        end
        if (frm_ack) begin
          vld_d   = 1'b0;
          state_d = ST_HDR0;
        end
      end
      default: begin
        // In-frame states: a byte on the expiry cycle still wins over the timeout.
        if (rx_vld) begin
          cnt_d = '0;
          case (state_q)
            ST_HDR1: begin
              if (rx_din == HDR1)      state_d = ST_CMD;
              else if (rx_din != HDR0) state_d = ST_HDR0;
            end
            ST_CMD: begin
              cmd_d   = rx_din;
              sum_d   = rx_din;
              state_d = ST_LEN;
            end
            ST_LEN: begin
              if (int'(rx_din) > MAX_LEN) begin
                err_d   = 1'b1;
                code_d  = ERR_LEN;
                state_d = ST_HDR0;
              end else begin
                len_d   = rx_din[ADDR_W:0];
                sum_d   = sum_q + rx_din;
                idx_d   = '0;
                state_d = (rx_din == 8'd0) ? ST_CHK : ST_DATA;
              end
            end
            ST_DATA: begin
              sum_d = sum_q + rx_din;
              idx_d = idx_q + 1'b1;
              if ({1'b0, idx_q} == len_q - 1'b1) state_d = ST_CHK;
            end
            ST_CHK: begin
              if (rx_din == sum_q) begin
                vld_d   = 1'b1;
                fcmd_d  = cmd_q;
                flen_d  = len_q;
                state_d = ST_HOLD;
              end else begin
                err_d   = 1'b1;
                code_d  = ERR_CHK;
                state_d = ST_HDR0;
              end
            end
            default: state_d = ST_HDR0;
          endcase
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          state_d = ST_HDR0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HDR0;
      cnt_q    <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      cmd_q    <= '0;
      len_q    <= '0;
      frm_vld  <= 1'b0;
      frm_cmd  <= '0;
      frm_len  <= '0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      frm_vld  <= vld_d;
      frm_cmd  <= fcmd_d;
      frm_len  <= flen_d;
      err      <= err_d;
      err_code <= code_d;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (rx_din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - self-checking bench for uart_frame_parser with a queue-based frame model
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 40;
  localparam int         ADDR_W  = 4;
  localparam logic [7:0] H0      = 8'h55;
  localparam logic [7:0] H1      = 8'hAA;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_din = '0;
  logic              rx_vld = 1'b0;
  logic              frm_ack = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              frm_vld;
  logic [7:0]        frm_cmd;
  logic [ADDR_W:0]   frm_len;
  logic [7:0]        rd_data;
  logic              err;
  logic [1:0]        err_code;

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd_on = 1'b0;

  // Model state: sync hunt flag, bytes of the current frame after 55 AA, hold flag, idle count.
  bit           m_have55 = 1'b0;
  bit           m_in = 1'b0;
  bit           m_hold = 1'b0;
  int           m_idle = 0;
  byte unsigned m_q[$];
  byte unsigned m_buf[MAX_LEN];
  bit           m_wr[MAX_LEN];
  bit           exp_vld = 1'b0;
  bit           exp_err = 1'b0;
  bit           exp_rd_ok = 1'b0;
  logic [7:0]   exp_cmd = '0;
  logic [7:0]   exp_rd = '0;
  int           exp_len = 0;
  int           exp_code = 0;

  byte unsigned fq[$];

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_din   (rx_din),
    .rx_vld   (rx_vld),
    .frm_vld  (frm_vld),
    .frm_cmd  (frm_cmd),
    .frm_len  (frm_len),
    .frm_ack  (frm_ack),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .err      (err),
    .err_code (err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) begin
      frm_ack = ($urandom_range(0, 15) == 0);
      rd_addr = ADDR_W'($urandom_range(0, MAX_LEN - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input logic [7:0] d);
    rx_vld = 1'b1;
    rx_din = d;
    tick();
    rx_vld = 1'b0;
  endtask

  task automatic send_fq();
    foreach (fq[i]) put(fq[i]);
  endtask

  task automatic ack();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
  endtask

  function automatic int rnd_gap();
    if ($urandom_range(0, 24) == 0) return TMO - 2 + int'($urandom_range(0, 2));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin : monitor
    bit         r, v, a;
    logic [7:0] d;
    int         ra, n, s;
    forever begin
      @(posedge clk);
      r = rst; v = rx_vld; d = rx_din; a = frm_ack; ra = int'(rd_addr);
      exp_err = 1'b0;
      if (r) begin
        m_have55 = 1'b0; m_in = 1'b0; m_hold = 1'b0; m_idle = 0; m_q.delete();
        exp_vld = 1'b0; exp_cmd = '0; exp_len = 0; exp_code = 0;
        exp_rd = '0; exp_rd_ok = 1'b1;
      end else begin
        exp_rd    = m_buf[ra];
        exp_rd_ok = m_wr[ra];
        if (m_hold) begin
          if (v) begin exp_err = 1'b1; exp_code = 0; end
          if (a) begin m_hold = 1'b0; exp_vld = 1'b0; end
        end else if (v) begin
          m_idle = 0;
          if (m_in) begin
            m_q.push_back(d);
            n = m_q.size();
            if (n == 2 && int'(d) > MAX_LEN) begin
              exp_err = 1'b1; exp_code = 2; m_in = 1'b0;
            end else if (n >= 3 && n <= int'(m_q[1]) + 2) begin
              m_buf[n-3] = d; m_wr[n-3] = 1'b1;
            end else if (n >= 3) begin
              s = 0;
              for (int i = 0; i < n - 1; i++) s += int'(m_q[i]);
              if ((s % 256) == int'(d)) begin
                m_hold = 1'b1; exp_vld = 1'b1; exp_cmd = m_q[0]; exp_len = int'(m_q[1]);
              end else begin
                exp_err = 1'b1; exp_code = 1;
              end
              m_in = 1'b0;
            end
          end else if (m_have55 && d == H1) begin
            m_in = 1'b1; m_have55 = 1'b0; m_q.delete();
          end else begin
            m_have55 = (d == H0);
          end
        end else if (m_have55 || m_in) begin
          m_idle++;
          if (m_idle == TMO) begin
            exp_err = 1'b1; exp_code = 3; m_in = 1'b0; m_have55 = 1'b0; m_idle = 0;
          end
        end
      end
      @(negedge clk);
      chk("mon_vld", 32'(frm_vld), 32'(exp_vld));
      if (exp_vld) begin
        chk("mon_cmd", 32'(frm_cmd), 32'(exp_cmd));
        chk("mon_len", 32'(frm_len), 32'(exp_len));
      end
      chk("mon_err", 32'(err), 32'(exp_err));
      if (exp_err) chk("mon_code", 32'(err_code), 32'(exp_code));
      if (exp_rd_ok) chk("mon_rd", 32'(rd_data), 32'(exp_rd));
    end
  end

  initial begin : stim
    int kind, len, s;
    logic [7:0] cmd, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(frm_vld), 32'd0);
    chk("rst_cmd", 32'(frm_cmd), 32'd0);
    chk("rst_len", 32'(frm_len), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    tick();

    fq = {H0, H1, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_fq();
    chk("good_vld", 32'(frm_vld), 32'd1);
    chk("good_cmd", 32'(frm_cmd), 32'h01);
    chk("good_len", 32'(frm_len), 32'd3);
    chk("good_err", 32'(err), 32'd0);
    rd_addr = 4'd0; tick(); chk("good_rd0", 32'(rd_data), 32'h11);
    rd_addr = 4'd1; tick(); chk("good_rd1", 32'(rd_data), 32'h22);
    rd_addr = 4'd2; tick(); chk("good_rd2", 32'(rd_data), 32'h33);
    ack();
    chk("ack_rel", 32'(frm_vld), 32'd0);

    fq = {H0, H1, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B};
    send_fq();
    chk("bchk_err", 32'(err), 32'd1);
    chk("bchk_code", 32'(err_code), 32'd1);
    chk("bchk_vld", 32'(frm_vld), 32'd0);
    tick();
    chk("bchk_pulse", 32'(err), 32'd0);
    fq = {H0, H1, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_fq();
    chk("bchk_next", 32'(frm_vld), 32'd1);
    ack();

    fq = {H0, H1, 8'h05, 8'h11};
    send_fq();
    chk("blen_err", 32'(err), 32'd1);
    chk("blen_code", 32'(err_code), 32'd2);
    fq = {8'h22, 8'h33, 8'h6A};
    send_fq();
    chk("blen_vld", 32'(frm_vld), 32'd0);
    chk("blen_quiet", 32'(err), 32'd0);

    fq = {H0, H0, H1, 8'h02, 8'h00, 8'h02};
    send_fq();
    chk("zero_vld", 32'(frm_vld), 32'd1);
    chk("zero_cmd", 32'(frm_cmd), 32'h02);
    chk("zero_len", 32'(frm_len), 32'd0);
    ack();

    fq = {H0, H1, 8'h01};
    send_fq();
    idle(TMO - 1);
    chk("tmo_early", 32'(err), 32'd0);
    tick();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd3);
    fq = {H0, H1, 8'h04, 8'h01, 8'h9C, 8'hA1};
    send_fq();
    chk("tmo_next_vld", 32'(frm_vld), 32'd1);
    chk("tmo_next_cmd", 32'(frm_cmd), 32'h04);
    rd_addr = 4'd0; tick(); chk("tmo_next_rd", 32'(rd_data), 32'h9C);
    ack();

    fq = {H0, H1, 8'h01};
    send_fq();
    idle(TMO - 1);
    fq = {8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_fq();
    chk("tmo_win_vld", 32'(frm_vld), 32'd1);
    ack();

    fq = {H0, H1, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_fq();
    for (int i = 0; i < 3; i++) begin
      put(8'h5A + 8'(i));
      chk("drop_err", 32'(err), 32'd1);
      chk("drop_code", 32'(err_code), 32'd0);
      chk("drop_cmd", 32'(frm_cmd), 32'h01);
      chk("drop_len", 32'(frm_len), 32'd3);
    end
    rx_vld = 1'b1; rx_din = H0; frm_ack = 1'b1;
    tick();
    rx_vld = 1'b0; frm_ack = 1'b0;
    chk("drop_ack_err", 32'(err), 32'd1);
    chk("drop_ack_vld", 32'(frm_vld), 32'd0);
    fq = {H1, 8'h01, 8'h00, 8'h01};
    send_fq();
    chk("drop_nosync", 32'(frm_vld), 32'd0);

    ack();
    fq = {H0, H1, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_fq();
    chk("stray_ack_vld", 32'(frm_vld), 32'd1);
    ack();

    fq = {H0, H1, 8'h01};
    send_fq();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_cmd", 32'(frm_cmd), 32'd0);
    fq = {8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_fq();
    chk("mid_rst_vld", 32'(frm_vld), 32'd0);

    rnd_on = 1'b1;
    repeat (400) begin
      kind = int'($urandom_range(0, 9));
      cmd  = 8'($urandom);
      fq.delete();
      if (kind <= 5) begin
        len = int'($urandom_range(0, MAX_LEN));
        s = int'(cmd) + len;
        fq = {H0, H1, cmd, 8'(len)};
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          fq.push_back(b);
          s += int'(b);
        end
        fq.push_back(8'(s + ((kind == 5) ? 1 : 0)));
      end else if (kind <= 7) begin
        len = int'($urandom_range(MAX_LEN + 1, 255));
        fq = {H0, H1, cmd, 8'(len)};
        repeat ($urandom_range(0, 3)) fq.push_back(8'($urandom));
      end else begin
        repeat ($urandom_range(1, 6)) begin
          case ($urandom_range(0, 2))
            0: fq.push_back(H0);
            1: fq.push_back(H1);
            default: fq.push_back(8'($urandom));
          endcase
        end
      end
      foreach (fq[i]) begin
        idle(rnd_gap());
        put(fq[i]);
      end
    end
    rnd_on = 1'b0;
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
